// File: rtl/avalon_burst_slave.sv
// Avalon-MM burst slave fronting a word buffer shared with a compute core,
// plus CTRL/STATUS registers for starting the core and observing done/error.
module avalon_burst_slave #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 13,
    parameter int BURST_W     = 10,
    parameter int MEM_DEPTH   = 4096,
    parameter int CTRL_ADDR   = 4126,
    parameter int STATUS_ADDR = 4127,
    localparam int MA_W       = $clog2(MEM_DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               write,
    input  logic               read,
    input  logic               beginbursttransfer,
    input  logic [BURST_W-1:0] burstcount,
    input  logic [ADDR_W-1:0]  address,
    input  logic [DATA_W-1:0]  writedata,
    output logic [DATA_W-1:0]  readdata,
    output logic               readdatavalid,
    output logic               waitrequest,
    output logic [1:0]         response,
    output logic               core_start,
    input  logic               core_busy,
    input  logic               core_done,
    input  logic [MA_W-1:0]    core_raddr,
    output logic [DATA_W-1:0]  core_rdata,
    input  logic               core_we,
    input  logic [MA_W-1:0]    core_waddr,
    input  logic [DATA_W-1:0]  core_wdata
);

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] CTRL_A  = ADDR_W'(CTRL_ADDR);
    localparam logic [ADDR_W-1:0] STAT_A  = ADDR_W'(STATUS_ADDR);

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [BURST_W-1:0]  cnt_q, cnt_d;
    logic [BURST_W-1:0]  beat_q, beat_d;
    logic                rdv_q, rdv_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          resp_q, resp_d;
    logic                start_q, start_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   core_rdata_q;

    logic [DATA_W-1:0]   mem [MEM_DEPTH];

    logic                acc_wr, acc_rd;
    logic [ADDR_W-1:0]   acc_addr;
    logic [BURST_W-1:0]  req_cnt;
    logic                is_buf, is_ctrl, is_stat, is_bad, ctrl_clr;
    logic [MA_W-1:0]     buf_idx;
    logic [DATA_W-1:0]   status;

    // A plain strobe is a one-beat burst; burstcount of 0 also means one beat.
    assign req_cnt = (!beginbursttransfer || burstcount == '0) ? BURST_W'(1) : burstcount;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        cnt_d    = cnt_q;
        beat_d   = beat_q;
        acc_wr   = 1'b0;
        acc_rd   = 1'b0;
        acc_addr = base_q + ADDR_W'(beat_q);
        unique case (state_q)
            IDLE: begin
                if (write) begin
                    base_d   = address;
                    cnt_d    = req_cnt;
                    beat_d   = BURST_W'(1);
                    acc_wr   = 1'b1;
                    acc_addr = address;
                    if (req_cnt != BURST_W'(1)) state_d = WR_BURST;
                end else if (read) begin
                    base_d   = address;
                    cnt_d    = req_cnt;
                    beat_d   = BURST_W'(1);
                    acc_rd   = 1'b1;
                    acc_addr = address;
                    state_d  = RD_BURST;
                end
            end
            WR_BURST: begin
                if (write) begin
                    acc_wr = 1'b1;
                    beat_d = beat_q + BURST_W'(1);
                    if (beat_d == cnt_q) state_d = IDLE;
                end
            end
            RD_BURST: begin
                // Beat 0 was issued on accept; the state lasts exactly cnt cycles.
                if (beat_q < cnt_q) begin
                    acc_rd = 1'b1;
                    beat_d = beat_q + BURST_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign is_buf   = acc_addr < DEPTH_A;
    assign is_ctrl  = acc_addr == CTRL_A;
    assign is_stat  = acc_addr == STAT_A;
    assign is_bad   = !(is_buf || is_ctrl || is_stat);
    assign buf_idx  = acc_addr[MA_W-1:0];
    assign status   = {{(DATA_W-3){1'b0}}, err_q, done_q, core_busy};
    assign ctrl_clr = acc_wr && is_ctrl && writedata[1];

    always_comb begin
        rdv_d   = acc_rd;
        resp_d  = (acc_rd && is_bad) ? 2'b10 : 2'b00;
        rdata_d = '0;
        if (acc_rd && is_buf)  rdata_d = mem[buf_idx];
        if (acc_rd && is_stat) rdata_d = status;
        start_d = acc_wr && is_ctrl && writedata[0];
        // Sets are applied after clears so they win on the same cycle.
        done_d  = ctrl_clr ? 1'b0 : done_q;
        if (core_done) done_d = 1'b1;
        err_d   = ctrl_clr ? 1'b0 : err_q;
        if ((acc_wr || acc_rd) && is_bad) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            base_q       <= '0;
            cnt_q        <= '0;
            beat_q       <= '0;
            rdv_q        <= 1'b0;
            rdata_q      <= '0;
            resp_q       <= 2'b00;
            start_q      <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            core_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            cnt_q        <= cnt_d;
            beat_q       <= beat_d;
            rdv_q        <= rdv_d;
            rdata_q      <= rdata_d;
            resp_q       <= resp_d;
            start_q      <= start_d;
            done_q       <= done_d;
            err_q        <= err_d;
            core_rdata_q <= mem[core_raddr];
        end
    end

    // Core write is applied last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (acc_wr && is_buf) mem[buf_idx] <= writedata;
            if (core_we)          mem[core_waddr] <= core_wdata;
        end
    end

    assign readdata      = rdata_q;
    assign readdatavalid = rdv_q;
    assign response      = resp_q;
    assign waitrequest   = (state_q == RD_BURST);
    assign core_start    = start_q;
    assign core_rdata    = core_rdata_q;

endmodule

// File: tb/tb_avalon_burst_slave.sv
// Directed bench for avalon_burst_slave: inputs driven and outputs sampled on the falling edge.
module tb_avalon_burst_slave;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write = 1'b0, read = 1'b0, beginbursttransfer = 1'b0;
    logic [9:0]  burstcount = '0;
    logic [12:0] address = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        readdatavalid, waitrequest;
    logic [1:0]  response;
    logic        core_start;
    logic        core_busy = 1'b0, core_done = 1'b0;
    logic [11:0] core_raddr = '0;
    logic [31:0] core_rdata;
    logic        core_we = 1'b0;
    logic [11:0] core_waddr = '0;
    logic [31:0] core_wdata = '0;

    int errors = 0;
    int checks = 0;

    logic [31:0] got_d [16];
    logic [1:0]  got_r [16];
    logic        got_v [16];
    logic        got_w [16];
    logic        post_v, post_w;

    localparam logic [12:0] CTRL = 13'd4126;
    localparam logic [12:0] STAT = 13'd4127;

    avalon_burst_slave dut (
        .clk(clk), .reset(reset), .write(write), .read(read),
        .beginbursttransfer(beginbursttransfer), .burstcount(burstcount),
        .address(address), .writedata(writedata), .readdata(readdata),
        .readdatavalid(readdatavalid), .waitrequest(waitrequest), .response(response),
        .core_start(core_start), .core_busy(core_busy), .core_done(core_done),
        .core_raddr(core_raddr), .core_rdata(core_rdata), .core_we(core_we),
        .core_waddr(core_waddr), .core_wdata(core_wdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic wr_burst(input logic [12:0] a, input int n, input logic [31:0] d0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            write = 1'b1; beginbursttransfer = (i == 0); address = a;
            burstcount = 10'(n); writedata = d0 + 32'(i);
        end
        @(negedge clk);
        write = 1'b0; beginbursttransfer = 1'b0;
    endtask

    task automatic wr_single(input logic [12:0] a, input logic [31:0] d);
        @(negedge clk);
        write = 1'b1; beginbursttransfer = 1'b0; address = a; burstcount = 10'd1; writedata = d;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic rd_burst(input logic [12:0] a, input int n);
        @(negedge clk);
        read = 1'b1; beginbursttransfer = 1'b1; address = a; burstcount = 10'(n);
        @(negedge clk);
        read = 1'b0; beginbursttransfer = 1'b0;
        for (int i = 0; i < n; i++) begin
            got_v[i] = readdatavalid; got_w[i] = waitrequest;
            got_d[i] = readdata;      got_r[i] = response;
            @(negedge clk);
        end
        post_v = readdatavalid; post_w = waitrequest;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_rdv got=%b exp=0", readdatavalid); end
        checks++; if (waitrequest !== 1'b0) begin errors++; $display("FAIL rst_wait got=%b exp=0", waitrequest); end
        checks++; if (response !== 2'b00) begin errors++; $display("FAIL rst_resp got=%b exp=00", response); end
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", readdata); end
        checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL rst_start got=%b exp=0", core_start); end
        checks++; if (core_rdata !== 32'h0) begin errors++; $display("FAIL rst_core_rdata got=%h exp=0", core_rdata); end
        reset = 1'b0;
        rd_burst(STAT, 1);
        checks++; if (got_d[0] !== 32'h0) begin errors++; $display("FAIL rst_status got=%h exp=0", got_d[0]); end
    endtask

    task automatic test_burst;
        wr_burst(13'h010, 4, 32'd1);
        rd_burst(13'h010, 4);
        for (int i = 0; i < 4; i++) begin
            checks++; if (got_v[i] !== 1'b1 || got_w[i] !== 1'b1) begin errors++; $display("FAIL burst_vw[%0d] got=%b%b exp=11", i, got_v[i], got_w[i]); end
            checks++; if (got_d[i] !== 32'(i + 1)) begin errors++; $display("FAIL burst_data[%0d] got=%h exp=%h", i, got_d[i], i + 1); end
            checks++; if (got_r[i] !== 2'b00) begin errors++; $display("FAIL burst_resp[%0d] got=%b exp=00", i, got_r[i]); end
        end
        checks++; if (post_v !== 1'b0 || post_w !== 1'b0) begin errors++; $display("FAIL burst_end got=%b%b exp=00", post_v, post_w); end
    endtask

    task automatic test_write_stall;
        @(negedge clk);
        write = 1'b1; beginbursttransfer = 1'b1; address = 13'h040; burstcount = 10'd3; writedata = 32'hA0;
        @(negedge clk);
        write = 1'b0; beginbursttransfer = 1'b0;
        checks++; if (waitrequest !== 1'b0) begin errors++; $display("FAIL wr_wait got=%b exp=0", waitrequest); end
        @(negedge clk);
        write = 1'b1; address = 13'h099; writedata = 32'hB0;
        @(negedge clk);
        writedata = 32'hC0;
        @(negedge clk);
        write = 1'b0;
        rd_burst(13'h040, 3);
        checks++; if (got_d[0] !== 32'hA0 || got_d[1] !== 32'hB0 || got_d[2] !== 32'hC0) begin
            errors++; $display("FAIL wr_stall got=%h,%h,%h exp=a0,b0,c0", got_d[0], got_d[1], got_d[2]);
        end
    endtask

    task automatic test_ctrl_start;
        @(negedge clk);
        write = 1'b1; beginbursttransfer = 1'b0; address = CTRL; writedata = 32'h1;
        checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL start_pre got=%b exp=0", core_start); end
        @(negedge clk);
        write = 1'b0;
        checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL start_pulse got=%b exp=1", core_start); end
        @(negedge clk);
        checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL start_post got=%b exp=0", core_start); end
    endtask

    task automatic test_status;
        core_busy = 1'b1;
        @(negedge clk); core_done = 1'b1;
        @(negedge clk); core_done = 1'b0;
        rd_burst(STAT, 1);
        checks++; if (got_d[0] !== 32'h3) begin errors++; $display("FAIL status_done got=%h exp=3", got_d[0]); end
        wr_single(CTRL, 32'h2);
        rd_burst(STAT, 1);
        checks++; if (got_d[0] !== 32'h1) begin errors++; $display("FAIL status_clr got=%h exp=1", got_d[0]); end
        rd_burst(CTRL, 1);
        checks++; if (got_d[0] !== 32'h0) begin errors++; $display("FAIL ctrl_read got=%h exp=0", got_d[0]); end
        core_busy = 1'b0;
    endtask

    task automatic test_range;
        wr_single(13'd4095, 32'hDEADBEEF);
        rd_burst(13'd4095, 3);
        checks++; if (got_d[0] !== 32'hDEADBEEF || got_r[0] !== 2'b00) begin errors++; $display("FAIL range_b0 got=%h/%b exp=deadbeef/00", got_d[0], got_r[0]); end
        checks++; if (got_d[1] !== 32'h0 || got_r[1] !== 2'b10) begin errors++; $display("FAIL range_b1 got=%h/%b exp=0/10", got_d[1], got_r[1]); end
        checks++; if (got_d[2] !== 32'h0 || got_r[2] !== 2'b10) begin errors++; $display("FAIL range_b2 got=%h/%b exp=0/10", got_d[2], got_r[2]); end
        checks++; if (post_v !== 1'b0 || response !== 2'b00) begin errors++; $display("FAIL range_idle got=%b/%b exp=0/00", post_v, response); end
        rd_burst(STAT, 1);
        checks++; if (got_d[0] !== 32'h4) begin errors++; $display("FAIL range_err got=%h exp=4", got_d[0]); end
        wr_single(CTRL, 32'h2);
    endtask

    task automatic test_wrap;
        wr_single(13'h0000, 32'h1234);
        rd_burst(13'h1FFF, 2);
        checks++; if (got_d[0] !== 32'h0 || got_r[0] !== 2'b10) begin errors++; $display("FAIL wrap_b0 got=%h/%b exp=0/10", got_d[0], got_r[0]); end
        checks++; if (got_d[1] !== 32'h1234 || got_r[1] !== 2'b00) begin errors++; $display("FAIL wrap_b1 got=%h/%b exp=1234/00", got_d[1], got_r[1]); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        read = 1'b1; beginbursttransfer = 1'b1; address = 13'h010; burstcount = 10'd8;
        @(negedge clk);
        read = 1'b0; beginbursttransfer = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (readdatavalid !== 1'b0 || waitrequest !== 1'b0) begin errors++; $display("FAIL midrst got=%b%b exp=00", readdatavalid, waitrequest); end
        rd_burst(13'h011, 1);
        checks++; if (got_v[0] !== 1'b1 || got_d[0] !== 32'h2 || post_v !== 1'b0) begin
            errors++; $display("FAIL midrst_read got=%b/%h/%b exp=1/2/0", got_v[0], got_d[0], post_v);
        end
        rd_burst(STAT, 1);
        checks++; if (got_d[0] !== 32'h0) begin errors++; $display("FAIL midrst_status got=%h exp=0", got_d[0]); end
    endtask

    task automatic test_collision;
        @(negedge clk);
        write = 1'b1; address = 13'd5; writedata = 32'h5555; beginbursttransfer = 1'b0;
        core_we = 1'b1; core_waddr = 12'd5; core_wdata = 32'hAAAA;
        @(negedge clk);
        write = 1'b0; core_we = 1'b0; core_raddr = 12'd5;
        @(negedge clk);
        checks++; if (core_rdata !== 32'hAAAA) begin errors++; $display("FAIL collide got=%h exp=aaaa", core_rdata); end
    endtask

    task automatic test_rdw;
        @(negedge clk);
        core_we = 1'b1; core_waddr = 12'd7; core_wdata = 32'h11;
        @(negedge clk);
        core_raddr = 12'd7; core_wdata = 32'h22;
        @(negedge clk);
        core_we = 1'b0;
        checks++; if (core_rdata !== 32'h11) begin errors++; $display("FAIL rdw_old got=%h exp=11", core_rdata); end
        @(negedge clk);
        checks++; if (core_rdata !== 32'h22) begin errors++; $display("FAIL rdw_new got=%h exp=22", core_rdata); end
    endtask

    task automatic test_both;
        @(negedge clk);
        write = 1'b1; read = 1'b1; beginbursttransfer = 1'b1; address = 13'h050;
        burstcount = 10'd1; writedata = 32'h77;
        @(negedge clk);
        write = 1'b0; read = 1'b0; beginbursttransfer = 1'b0;
        checks++; if (waitrequest !== 1'b0 || readdatavalid !== 1'b0) begin errors++; $display("FAIL both_ignore got=%b%b exp=00", waitrequest, readdatavalid); end
        rd_burst(13'h050, 1);
        checks++; if (got_d[0] !== 32'h77) begin errors++; $display("FAIL both_data got=%h exp=77", got_d[0]); end
    endtask

    task automatic test_bc0;
        @(negedge clk);
        write = 1'b1; beginbursttransfer = 1'b1; address = 13'h020; burstcount = 10'd0; writedata = 32'h5A;
        @(negedge clk);
        beginbursttransfer = 1'b0; address = 13'h030; writedata = 32'h6B;
        @(negedge clk);
        write = 1'b0;
        rd_burst(13'h030, 1);
        checks++; if (got_d[0] !== 32'h6B) begin errors++; $display("FAIL bc0_second got=%h exp=6b", got_d[0]); end
        rd_burst(13'h020, 1);
        checks++; if (got_d[0] !== 32'h5A) begin errors++; $display("FAIL bc0_first got=%h exp=5a", got_d[0]); end
    endtask

    initial begin
        test_reset;
        test_burst;
        test_write_stall;
        test_ctrl_start;
        test_status;
        test_range;
        test_wrap;
        test_reset_mid;
        test_collision;
        test_rdw;
        test_both;
        test_bc0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
